// File: rtl/addsub_pkg.sv
// Shared encodings for the serial nibble add/sub sequencer.
package addsub_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/result bundle between a requester and serial_addsub_ctrl.
interface serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         ctrl;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         crry;
  logic         ovf;

  modport master (output start, ctrl, in1, in2,
                  input  busy, done, sum, crry, ovf);
  modport slave  (input  start, ctrl, in1, in2,
                  output busy, done, sum, crry, ovf);
endinterface

// File: rtl/nibble_addsub.sv
// One 4-bit add/sub slice; cin is separate from sub so carries chain between nibbles.
module nibble_addsub
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3
);
  logic [NIBBLE_W-1:0] w_bx;
  logic [3:0]          w_lo;
  logic [1:0]          w_hi;

  assign w_bx = b ^ {NIBBLE_W{sub}};
  assign w_lo = {1'b0, a[2:0]} + {1'b0, w_bx[2:0]} + {3'b000, cin};
  assign c3   = w_lo[3];
  assign w_hi = {1'b0, a[3]} + {1'b0, w_bx[3]} + {1'b0, c3};
  assign s    = {w_hi[0], w_lo[2:0]};
  assign cout = w_hi[1];
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Multi-precision add/sub sequencer: one nibble slice per cycle, LS nibble first.
// Build option: define SERIAL_ADDSUB_OVF_EN to register the signed overflow flag.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
)(
  input  logic                clk,
  input  logic                rst_n,
  serial_addsub_ctrl_if.slave bus
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  state_t             r_state, w_next;
  logic [W-1:0]       r_a, r_b, r_sum;
  logic               r_op, r_carry, r_crry;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W+1:0]   w_sh;
  logic [NIBBLE_W-1:0] w_a_nib, w_b_nib, w_s;
  logic               w_cout, w_c3, w_last;

  assign w_sh    = {r_idx, 2'b00};
  assign w_a_nib = NIBBLE_W'(r_a >> w_sh);
  assign w_b_nib = NIBBLE_W'(r_b >> w_sh);
  assign w_last  = (r_idx == IDX_W'(NIBBLES - 1));

  nibble_addsub u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .sub  (r_op),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout),
    .c3   (w_c3)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_crry  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_a     <= bus.in1;
          r_b     <= bus.in2;
          r_op    <= bus.ctrl;
          r_carry <= bus.ctrl;  // +1 of the two's complement for subtract
          r_idx   <= '0;
        end
        RUN: begin
          r_sum   <= (r_sum & ~(W'(4'hF) << w_sh)) | (W'(w_s) << w_sh);
          r_carry <= w_cout;
          if (w_last) begin
            r_idx  <= '0;
            r_crry <= w_cout;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (!rst_n)                         r_ovf <= 1'b0;
    else if (r_state == RUN && w_last)  r_ovf <= w_c3 ^ w_cout;
  end
  assign bus.ovf = r_ovf;
`else
  logic w_unused_c3;
  assign w_unused_c3 = w_c3;
  assign bus.ovf     = 1'b0;
`endif

  assign bus.busy = (r_state == RUN) || (r_state == DONE);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.crry = r_crry;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl with NIBBLES=4.
module tb_serial_addsub_ctrl;
`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   lat;

  serial_addsub_ctrl_if #(.NIBBLES(4)) bus ();

  serial_addsub_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in cycle 1 of an operation; returns the cycle in which done is seen.
  task automatic wait_done(input string tag, output int n);
    n = 1;
    while (bus.done !== 1'b1 && n < 12) begin
      chk({tag, "_busy_run"}, {31'd0, bus.busy}, 32'd1);
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd5);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic op, input logic [15:0] esum, input logic ecry,
                        input logic eovf);
    int n;
    bus.in1 = a; bus.in2 = b; bus.ctrl = op; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(tag, n);
    chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, "_sum"},  {16'd0, bus.sum}, {16'd0, esum});
    chk({tag, "_crry"}, {31'd0, bus.crry}, {31'd0, ecry});
    chk({tag, "_ovf"},  {31'd0, bus.ovf},  {31'd0, eovf & OVF_EN});
    tick();
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_busy_idle"},  {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.ctrl = 1'b0; bus.in1 = '0; bus.in2 = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sum",  {16'd0, bus.sum},  32'd0);
    chk("rst_crry", {31'd0, bus.crry}, 32'd0);
    chk("rst_ovf",  {31'd0, bus.ovf},  32'd0);
    rst_n = 1'b1;
    tick();

    run_op("add",      16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("sub",      16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 1'b0);
    run_op("sub_brw",  16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_sum",  {16'd0, bus.sum},  32'd0);
      chk("hold_crry", {31'd0, bus.crry}, 32'd1);
      chk("hold_done", {31'd0, bus.done}, 32'd0);
      tick();
    end
    run_op("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("ovf_none", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);

    // start pulses in cycles 2 and 5 must be ignored; cycle 6 start is accepted
    bus.in1 = 16'h1234; bus.in2 = 16'h0FFF; bus.ctrl = 1'b0; bus.start = 1'b1;
    tick();                                               // cycle 1
    bus.start = 1'b0;
    tick();                                               // cycle 2
    bus.in1 = 16'hAAAA; bus.in2 = 16'h5555; bus.ctrl = 1'b1; bus.start = 1'b1;
    tick();                                               // cycle 3
    bus.start = 1'b0;
    tick(); tick();                                       // cycle 5
    bus.in1 = 16'hFFFF; bus.in2 = 16'hFFFF; bus.ctrl = 1'b0; bus.start = 1'b1;
    chk("ign_done5", {31'd0, bus.done}, 32'd1);
    chk("ign_sum",   {16'd0, bus.sum},  32'h2233);
    chk("ign_crry",  {31'd0, bus.crry}, 32'd0);
    tick();                                               // cycle 6
    bus.start = 1'b0;
    chk("ign_done6", {31'd0, bus.done}, 32'd0);
    chk("ign_busy6", {31'd0, bus.busy}, 32'd0);
    bus.in1 = 16'h0003; bus.in2 = 16'h0004; bus.ctrl = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("b2b", lat);
    chk("b2b_sum", {16'd0, bus.sum}, 32'h0007);
    tick();

    // reset in cycle 3 aborts the operation without a done pulse
    bus.in1 = 16'h1234; bus.in2 = 16'h0FFF; bus.ctrl = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();                                       // cycle 3
    rst_n = 1'b0;
    tick();
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_sum",  {16'd0, bus.sum},  32'd0);
    chk("abort_crry", {31'd0, bus.crry}, 32'd0);
    chk("abort_ovf",  {31'd0, bus.ovf},  32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", {31'd0, bus.done}, 32'd0);
      tick();
    end
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
